// File: rtl/uart_cmd_led_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_led_sched
// Brief   : Parses 8-byte UART command frames (HDR0 HDR1 T3..T0 CTRL TAIL) and
//           steps the LED through the committed 8-phase pattern. Optional
//           FRAME_CHECKSUM_EN adds an XOR checksum byte before the tail.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_led_sched #(
    parameter logic [7:0]  HDR0         = 8'h55,
    parameter logic [7:0]  HDR1         = 8'hA5,
    parameter logic [7:0]  TAIL         = 8'hF0,
    parameter logic [31:0] DEF_TIME     = 32'd25_000_000,
    parameter logic [7:0]  DEF_CTRL     = 8'hAA,
    parameter logic [19:0] BYTE_TIMEOUT = 20'd100_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        Led,
    output logic [31:0] time_set,
    output logic [7:0]  ctrl_set,
    output logic        frame_ok,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_HDR1 = 4'd1,
        S_T3   = 4'd2,
        S_T2   = 4'd3,
        S_T1   = 4'd4,
        S_T0   = 4'd5,
        S_CTRL = 4'd6,
        S_TAIL = 4'd7
`ifdef FRAME_CHECKSUM_EN
        , S_CSUM = 4'd8
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_to_cnt;
    logic [31:0] r_shadow_time;
    logic [7:0]  r_shadow_ctrl;
    logic [31:0] r_cnt;
    logic [2:0]  r_phase;
    logic        w_commit;
    logic        w_reject;
    logic        w_timeout;
    logic        w_tail_ok;

`ifdef FRAME_CHECKSUM_EN
    logic       r_csum_bad;
    logic [7:0] w_csum_calc;
    assign w_csum_calc = r_shadow_time[31:24] ^ r_shadow_time[23:16] ^
                         r_shadow_time[15:8]  ^ r_shadow_time[7:0]   ^ r_shadow_ctrl;
    assign w_tail_ok   = (rx_data == TAIL) && (r_shadow_time != 32'd0) && !r_csum_bad;
`else
    assign w_tail_ok   = (rx_data == TAIL) && (r_shadow_time != 32'd0);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A received byte always takes precedence over an expiring timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        w_timeout   = 1'b0;
        if (rx_done) begin
            case (r_state)
                S_IDLE: if (rx_data == HDR0) w_state_nxt = S_HDR1;
                S_HDR1: begin
                    if      (rx_data == HDR1) w_state_nxt = S_T3;
                    else if (rx_data == HDR0) w_state_nxt = S_HDR1;
                    else                      w_state_nxt = S_IDLE;
                end
                S_T3:   w_state_nxt = S_T2;
                S_T2:   w_state_nxt = S_T1;
                S_T1:   w_state_nxt = S_T0;
                S_T0:   w_state_nxt = S_CTRL;
`ifdef FRAME_CHECKSUM_EN
                S_CTRL: w_state_nxt = S_CSUM;
                S_CSUM: w_state_nxt = S_TAIL;
`else
                S_CTRL: w_state_nxt = S_TAIL;
`endif
                S_TAIL: begin
                    w_state_nxt = S_IDLE;
                    w_commit    = w_tail_ok;
                    w_reject    = !w_tail_ok;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if ((r_state != S_IDLE) && (r_to_cnt == BYTE_TIMEOUT - 20'd1)) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || rx_done || (r_state == S_IDLE) || w_timeout) r_to_cnt <= 20'd0;
        else                                                     r_to_cnt <= r_to_cnt + 20'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset || w_timeout) begin
            r_shadow_time <= 32'd0;
            r_shadow_ctrl <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
            r_csum_bad    <= 1'b0;
`endif
        end else if (rx_done) begin
            case (r_state)
                S_T3:   r_shadow_time[31:24] <= rx_data;
                S_T2:   r_shadow_time[23:16] <= rx_data;
                S_T1:   r_shadow_time[15:8]  <= rx_data;
                S_T0:   r_shadow_time[7:0]   <= rx_data;
                S_CTRL: r_shadow_ctrl        <= rx_data;
`ifdef FRAME_CHECKSUM_EN
                S_CSUM: r_csum_bad           <= (rx_data != w_csum_calc);
`endif
                default: ;
            endcase
        end
    end

    // Commit restarts the pattern and wins over a coincident period end.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            time_set  <= DEF_TIME;
            ctrl_set  <= DEF_CTRL;
            r_cnt     <= 32'd0;
            r_phase   <= 3'd0;
            Led       <= DEF_CTRL[0];
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= w_commit;
            frame_err <= w_reject || w_timeout;
            if (w_commit) begin
                time_set <= r_shadow_time;
                ctrl_set <= r_shadow_ctrl;
                r_cnt    <= 32'd0;
                r_phase  <= 3'd0;
                Led      <= r_shadow_ctrl[0];
            end else if (r_cnt == time_set - 32'd1) begin
                r_cnt   <= 32'd0;
                r_phase <= r_phase + 3'd1;
                Led     <= ctrl_set[r_phase + 3'd1];
            end else begin
                r_cnt   <= r_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_led_sched.md
Name: uart_cmd_led_sched

Overview:
- Frame parser and LED pattern scheduler between the uart_byte_rx receiver and the board LED.
- Assembles 8-byte command frames from received bytes and validates header and tail.
- Commits a new blink period and 8-phase pattern only on a valid frame.
- Steps the LED through the pattern, one bit per period, continuously.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hA5, second header byte
TAIL, 8'hF0, frame tail byte
DEF_TIME, 32'd25_000_000, period in Clk cycles loaded at reset (0.5 s at 50 MHz)
DEF_CTRL, 8'hAA, LED pattern loaded at reset
BYTE_TIMEOUT, 20'd100_000, max Clk cycles between bytes inside a frame

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle strobe from uart_byte_rx
Led  output  1  LED drive, registered
time_set  output  32  committed phase period in cycles
ctrl_set  output  8  committed pattern, bit n drives Led in phase n
frame_ok  output  1  one-cycle pulse on commit
frame_err  output  1  one-cycle pulse on rejected or aborted frame

Behaviour:
- Reset: parser state=S_IDLE, time_set=DEF_TIME, ctrl_set=DEF_CTRL, phase=0, cnt=0, Led=DEF_CTRL[0], frame_ok=0, frame_err=0, timeout counter=0.
- Frame byte order: HDR0, HDR1, T[31:24], T[23:16], T[15:8], T[7:0], CTRL, TAIL. T is big-endian.
- Parser states: S_IDLE, S_HDR1, S_T3, S_T2, S_T1, S_T0, S_CTRL, S_TAIL. The parser advances only on rx_done.
  - S_IDLE: byte==HDR0 -> S_HDR1; any other byte is ignored.
  - S_HDR1: byte==HDR1 -> S_T3; byte==HDR0 -> stay in S_HDR1 (resync); any other byte -> S_IDLE. No error pulse in either case.
  - S_T3..S_T0 and S_CTRL: latch the byte into the shadow time or shadow ctrl register, then advance to the next state.
  - S_TAIL: byte==TAIL and shadow time!=0 -> commit, then S_IDLE.
  - S_TAIL: byte!=TAIL, or shadow time==0 -> frame_err pulse, keep old config, then S_IDLE.
- Commit (registered on the cycle after the tail rx_done):
  - time_set and ctrl_set take the shadow values; frame_ok=1 for one cycle.
  - Sequencer restarts: cnt=0, phase=0, Led=new ctrl[0].
- Timeout:
  - Counter runs only while state!=S_IDLE and clears on every rx_done.
  - On reaching BYTE_TIMEOUT-1: state -> S_IDLE, frame_err pulse, shadow values discarded.
- Sequencer:
  - cnt counts 0..time_set-1.
  - At cnt==time_set-1: cnt=0, phase=phase+1 with 3-bit wrap (7 -> 0), Led=ctrl_set[phase+1] on the same edge.
  - Each phase therefore holds Led for exactly time_set cycles.
- Simultaneous events:
  - Commit and period end in the same cycle: commit wins.
  - rx_done and timeout in the same cycle: rx_done wins; the byte is processed and the counter cleared.
  - Reset mid-frame or mid-phase restores all reset values on the next edge.
- frame_ok and frame_err are never high in the same cycle.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- When defined:
  - Frame is 9 bytes; a checksum byte sits between CTRL and TAIL, handled by an extra state S_CSUM.
  - Checksum = XOR of T3, T2, T1, T0 and CTRL.
  - Mismatch is recorded; at tail the frame is rejected with frame_err. A wrong tail is also rejected.
- When undefined: 8-byte frame; no S_CSUM state and no checksum logic.

Test Plan:
- Bytes 55 A5 12 34 56 78 9A F0 -> frame_ok pulse; time_set=32'h12345678; ctrl_set=8'h9A; Led=0 (bit 0 of 8'h9A).
- Bytes 55 A5 00 00 00 04 9A F0 -> Led sequence 0,1,0,1,1,0,0,1, each held exactly 4 cycles, then repeating from phase 0.
- Bytes 55 A5 00 00 00 04 9A 0F -> frame_err pulse; time_set and ctrl_set unchanged (DEF values after reset).
- Bytes 55 55 A5 00 00 00 08 0F F0 -> resync on the second 55; frame_ok pulse; time_set=8; ctrl_set=8'h0F.
- Bytes 55 A5 12, then no byte for BYTE_TIMEOUT cycles -> frame_err pulse; parser back in S_IDLE; a following valid frame commits normally.
- With FRAME_CHECKSUM_EN: bytes 55 A5 12 34 56 78 9A 92 F0 -> frame_ok. The same frame with checksum 93 -> frame_err; config unchanged. Bytes 55 A5 00 00 00 00 9A 9A F0 (time 0) -> frame_err.
